// File: rtl/mesh_term_tx.sv
// Terminal-side injection port: formats client fields into mesh packets, buffers them, and offers the head to the router.
// Latency: a legal push into an empty FIFO appears on pndng_o/data_o one cycle later; the head is first-word-fall-through.
// Backpressure: full_o is raised at FIFO_DEPTH. Pushes while full without popin_i are dropped; optional stats via MESH_TERM_TX_STATS_EN.
module mesh_term_tx #(
  parameter int          ROWS       = 4,
  parameter int          COLUMNS    = 4,
  parameter int          PAKG_SIZE  = 32,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  BDCST      = 8'hFF
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            push_i,
  input  logic [3:0]                      row_i,
  input  logic [3:0]                      col_i,
  input  logic                            mode_i,
  input  logic                            bcast_i,
  input  logic [PAKG_SIZE-18:0]           payload_i,
  output logic                            full_o,
  output logic [$clog2(FIFO_DEPTH):0]     count_o,
  output logic                            pndng_o,
  output logic [PAKG_SIZE-1:0]            data_o,
  input  logic                            popin_i,
  output logic                            ovf_o,
  output logic                            addr_err_o,
  output logic                            unf_o
`ifdef MESH_TERM_TX_STATS_EN
  ,
  output logic [31:0]                     sent_o,
  output logic [15:0]                     drop_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0]    ROW_MAX  = 4'(ROWS);
  localparam logic [3:0]    COL_MAX  = 4'(COLUMNS);
  localparam logic [3:0]    ROW_LAST = 4'(ROWS + 1);
  localparam logic [3:0]    COL_LAST = 4'(COLUMNS + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  logic [PAKG_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count_q;
  logic [PAKG_SIZE-1:0] hold_q;
  logic                 ovf_q, addr_err_q, unf_q;

  logic                 empty, full;
  logic                 addr_ok, legal_push;
  logic                 do_push, do_pop, ovf_evt, addr_evt;
  logic [7:0]           rc_field;
  logic [PAKG_SIZE-1:0] pkt;

  // Target legality, packet formatting and push/pop decisions for this cycle.
  always_comb begin
    addr_ok    = (((row_i == 4'h0) || (row_i == ROW_LAST)) && (col_i != 4'h0) && (col_i <= COL_MAX)) ||
                 (((col_i == 4'h0) || (col_i == COL_LAST)) && (row_i != 4'h0) && (row_i <= ROW_MAX));
    rc_field   = bcast_i ? BDCST : {row_i, col_i};
    pkt        = {8'h00, rc_field, mode_i, payload_i};
    empty      = (count_q == '0);
    full       = (count_q == DEPTH_C);
    do_pop     = popin_i && !empty;
    legal_push = push_i && (bcast_i || addr_ok);
    // A pop in the same cycle frees the slot the push needs, so full does not block it.
    do_push    = legal_push && (!full || do_pop);
    ovf_evt    = legal_push && full && !do_pop;
    addr_evt   = push_i && !bcast_i && !addr_ok;
  end

  // Packet storage; contents are don't-care until pointed at by a valid occupancy.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= pkt;
  end

  // Pointers, occupancy, last-head capture and sticky error flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      ovf_q      <= 1'b0;
      addr_err_q <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
      // Keeps the most recent head so data_o holds once the FIFO drains.
      if (!empty) hold_q <= mem[rd_ptr];
      if (ovf_evt)            ovf_q      <= 1'b1;
      if (addr_evt)           addr_err_q <= 1'b1;
      if (popin_i && empty)   unf_q      <= 1'b1;
    end
  end

`ifdef MESH_TERM_TX_STATS_EN
  logic [31:0] sent_q;
  logic [15:0] drop_q;

  // Saturating counters of retired packets and dropped pushes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sent_q <= '0;
      drop_q <= '0;
    end else begin
      if (do_pop && (sent_q != '1))                 sent_q <= sent_q + 1'b1;
      if ((ovf_evt || addr_evt) && (drop_q != '1))  drop_q <= drop_q + 1'b1;
    end
  end

  assign sent_o = sent_q;
  assign drop_o = drop_q;
`endif

  assign full_o     = full;
  assign count_o    = count_q;
  assign pndng_o    = !empty;
  assign data_o     = empty ? hold_q : mem[rd_ptr];
  assign ovf_o      = ovf_q;
  assign addr_err_o = addr_err_q;
  assign unf_o      = unf_q;

endmodule

// File: tb/tb_mesh_term_tx.sv
// Bench for mesh_term_tx: directed scenarios plus randomized push/pop traffic.
// Stimulus updates a queue-based reference model; a negedge monitor checks every head the router consumes.
// Builds with or without MESH_TERM_TX_STATS_EN.
module tb_mesh_term_tx;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        push_i = 1'b0;
  logic [3:0]  row_i = '0;
  logic [3:0]  col_i = '0;
  logic        mode_i = 1'b0;
  logic        bcast_i = 1'b0;
  logic [14:0] payload_i = '0;
  logic        popin_i = 1'b0;
  logic        full_o, pndng_o, ovf_o, addr_err_o, unf_o;
  logic [4:0]  count_o;
  logic [31:0] data_o;
`ifdef MESH_TERM_TX_STATS_EN
  logic [31:0] sent_o;
  logic [15:0] drop_o;
`endif

  mesh_term_tx #(.ROWS(4), .COLUMNS(4), .PAKG_SIZE(32), .FIFO_DEPTH(DEPTH), .BDCST(8'hFF)) dut (
    .clk_i(clk), .rst_i(rst_i), .push_i(push_i), .row_i(row_i), .col_i(col_i),
    .mode_i(mode_i), .bcast_i(bcast_i), .payload_i(payload_i),
    .full_o(full_o), .count_o(count_o), .pndng_o(pndng_o), .data_o(data_o),
    .popin_i(popin_i), .ovf_o(ovf_o), .addr_err_o(addr_err_o), .unf_o(unf_o)
`ifdef MESH_TERM_TX_STATS_EN
    , .sent_o(sent_o), .drop_o(drop_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] mq[$];      // model FIFO contents
  logic [31:0] sb_q[$];    // scoreboard of packets expected at the router
  logic [31:0] last_dat = '0;
  bit m_ovf = 0, m_aerr = 0, m_unf = 0;
  int m_sent = 0, m_drop = 0;
  bit legal_tab [256];
  logic [7:0] terms [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_pkt(input logic [3:0] r, input logic [3:0] c,
                                         input bit m, input bit b, input logic [14:0] p);
    logic [7:0] rc;
    rc = b ? 8'hFF : {r, c};
    return {8'h00, rc, m, p};
  endfunction

  // Router-side monitor: whatever is pending must be the oldest expected packet.
  always @(negedge clk) begin
    if (rst_i && pndng_o) begin
      if (sb_q.size() == 0) chk("mon_unexpected_pndng", 1, 0);
      else begin
        chk("mon_head", data_o, sb_q[0]);
        if (popin_i) void'(sb_q.pop_front());
      end
    end
  end

  task automatic clear_model();
    mq.delete(); sb_q.delete();
    last_dat = '0; m_ovf = 0; m_aerr = 0; m_unf = 0; m_sent = 0; m_drop = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, count_o, mq.size());
    chk({tag, "_full"}, full_o, (mq.size() == DEPTH));
    chk({tag, "_pndng"}, pndng_o, (mq.size() != 0));
    chk({tag, "_ovf"}, ovf_o, m_ovf);
    chk({tag, "_aerr"}, addr_err_o, m_aerr);
    chk({tag, "_unf"}, unf_o, m_unf);
    if (mq.size() == 0) chk({tag, "_hold"}, data_o, last_dat);
`ifdef MESH_TERM_TX_STATS_EN
    chk({tag, "_sent"}, sent_o, m_sent);
    chk({tag, "_drop"}, drop_o, m_drop);
`endif
  endtask

  // One clock of stimulus; the model decides outcomes from the rules, then state is checked after the edge.
  task automatic step(input string tag, input bit push, input logic [3:0] r, input logic [3:0] c,
                      input bit m, input bit b, input logic [14:0] p, input bit pop);
    bit empty0, legal, dpop, acc;
    logic [31:0] pkt;
    push_i = push; row_i = r; col_i = c; mode_i = m; bcast_i = b; payload_i = p; popin_i = pop;
    empty0 = (mq.size() == 0);
    legal  = b || legal_tab[{r, c}];
    dpop   = pop && !empty0;
    acc    = push && legal && ((mq.size() < DEPTH) || dpop);
    pkt    = mk_pkt(r, c, m, b, p);
    if (pop && empty0) m_unf = 1;
    if (push && !legal) begin m_aerr = 1; m_drop++; end
    if (push && legal && !acc) begin m_ovf = 1; m_drop++; end
    if (dpop) begin last_dat = mq.pop_front(); m_sent++; end
    if (acc) begin mq.push_back(pkt); sb_q.push_back(pkt); end
    @(posedge clk); #1;
    check_state(tag);
    push_i = 0; popin_i = 0; bcast_i = 0;
  endtask

  task automatic rand_addr(output logic [3:0] r, output logic [3:0] c, output bit b);
    logic [7:0] a;
    b = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 1) == 0) begin
      a = terms[$urandom_range(0, terms.size() - 1)];
      r = a[7:4]; c = a[3:0];
    end else begin
      r = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    logic [3:0] r, c;
    bit b;
    int guard;
    // Terminal addresses enumerated from the mesh edges.
    for (int i = 0; i < 256; i++) legal_tab[i] = 0;
    for (int k = 1; k <= 4; k++) begin
      terms.push_back(8'(0 * 16 + k));
      terms.push_back(8'(5 * 16 + k));
      terms.push_back(8'(k * 16 + 0));
      terms.push_back(8'(k * 16 + 5));
    end
    foreach (terms[i]) legal_tab[terms[i]] = 1;

    // Reset state
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    chk("reset_data", data_o, 32'h0);
    rst_i = 1;

    // Single packet, exact format
    step("p1", 1, 4'd0, 4'd1, 1, 0, 15'h1234, 0);
    chk("p1_data", data_o, 32'h0001_9234);
    step("p1_pop", 0, 0, 0, 0, 0, 0, 1);

    // Illegal interior target then a legal bottom-edge target
    step("illegal", 1, 4'd2, 4'd2, 0, 0, 15'h0055, 0);
    step("row5", 1, 4'd5, 4'd3, 0, 0, 15'h0066, 0);
    step("row5_pop", 0, 0, 0, 0, 0, 0, 1);

    // Fill to full, push+pop while full, overflow, then drain in order
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 4'd0, 4'(1 + i % 4), 0, 0, 15'(i), 0);
    step("full_pp", 1, 4'd1, 4'd0, 1, 0, 15'h0100, 1);
    step("ovf", 1, 4'd0, 4'd2, 0, 0, 15'h0200, 0);
    guard = 0;
    while (mq.size() != 0 && guard < 40) begin step("drain", 0, 0, 0, 0, 0, 0, 1); guard++; end
    chk("drain_done", mq.size(), 0);

    // Underflow, then broadcast format
    step("unf", 0, 0, 0, 0, 0, 0, 1);
    step("bcast", 1, 4'd9, 4'd9, 0, 1, 15'h0007, 0);
    chk("bcast_data", data_o, 32'h00FF_0007);
    step("bcast_pp", 1, 4'd4, 4'd5, 0, 0, 15'h0011, 1);
    step("bcast_pop", 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic, push-heavy then pop-heavy
    for (int i = 0; i < 400; i++) begin
      int pp, qp;
      pp = (i < 200) ? 80 : 30;
      qp = (i < 200) ? 30 : 70;
      rand_addr(r, c, b);
      step("rnd", ($urandom_range(0, 99) < pp), r, c, 1'($urandom_range(0, 1)), b,
           15'($urandom_range(0, 32767)), ($urandom_range(0, 99) < qp));
    end

    // Reset mid-stream with packets buffered
    guard = 0;
    while (mq.size() != 0 && guard < 40) begin step("pre_rst", 0, 0, 0, 0, 0, 0, 1); guard++; end
    for (int i = 0; i < 5; i++) step("five", 1, 4'd3, 4'd0, 0, 0, 15'(100 + i), 0);
    chk("five_count", count_o, 5);
    #2 rst_i = 0;
    #1;
    clear_model();
    check_state("async_rst");
    chk("async_rst_data", data_o, 32'h0);
    @(posedge clk); #1;
    rst_i = 1;
    step("after_rst", 1, 4'd0, 4'd4, 1, 0, 15'h0ABC, 0);
    step("after_rst_pop", 0, 0, 0, 0, 0, 0, 1);
    step("idle", 0, 0, 0, 0, 0, 0, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
